// File: rtl/uart_program_loader.sv
// Program-load controller: halts the CPU on a load-button press, then streams a
// little-endian word count and that many little-endian words into instruction memory.
module uart_program_loader #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              wait_transport,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              loading,
  output logic [ADDR_W:0]   prog_len,
  output logic              load_err
);

  typedef enum logic [2:0] {RUN, CNT_LO, CNT_HI, INS_LO, INS_HI, DONE, ERR} state_e;

  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_e            state_q, state_d;
  logic              btnCur_q, btnPrev_q;
  logic [7:0]        lowByte_q, lowByte_d;
  logic [ADDR_W:0]   index_q, index_d;
  logic [31:0]       timer_q, timer_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              loading_q, loading_d;
  logic [ADDR_W:0]   progLen_q, progLen_d;
  logic              err_q, err_d;

  logic              btnEdge;
  logic              accepted;
  logic              timeoutHit;
  logic              loadState;
  logic [16:0]       countExt;
  logic [ADDR_W:0]   indexInc;

  assign btnEdge    = btnPrev_q & ~btnCur_q;
  assign accepted   = rx_valid & ~btnEdge;
  assign timeoutHit = (TIMEOUT_CYCLES != 32'd0) && (timer_q == 32'(TIMEOUT_CYCLES - 32'd1));
  assign loadState  = (state_q == CNT_LO) || (state_q == CNT_HI) ||
                      (state_q == INS_LO) || (state_q == INS_HI);
  assign countExt   = {1'b0, rx_data, lowByte_q};
  assign indexInc   = index_q + {{ADDR_W{1'b0}}, 1'b1};

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= RUN;
      btnCur_q  <= 1'b1;
      btnPrev_q <= 1'b1;
      lowByte_q <= '0;
      index_q   <= '0;
      timer_q   <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      hold_q    <= 1'b0;
      loading_q <= 1'b0;
      progLen_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      btnCur_q  <= wait_transport;
      btnPrev_q <= btnCur_q;
      lowByte_q <= lowByte_d;
      index_q   <= index_d;
      timer_q   <= timer_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      hold_q    <= hold_d;
      loading_q <= loading_d;
      progLen_q <= progLen_d;
      err_q     <= err_d;
    end
  end

  // A button edge overrides everything, including a byte arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    if (btnEdge) begin
      state_d = CNT_LO;
    end else begin
      unique case (state_q)
        CNT_LO: if (rx_valid) state_d = CNT_HI;
                else if (timeoutHit) state_d = ERR;
        CNT_HI: if (rx_valid) begin
                  if (countExt == 17'd0)     state_d = DONE;
                  else if (countExt > DEPTH) state_d = ERR;
                  else                       state_d = INS_LO;
                end else if (timeoutHit) state_d = ERR;
        INS_LO: if (rx_valid) state_d = INS_HI;
                else if (timeoutHit) state_d = ERR;
        INS_HI: if (rx_valid) state_d = (indexInc == progLen_q) ? DONE : INS_LO;
                else if (timeoutHit) state_d = ERR;
        default: state_d = state_q;
      endcase
    end
  end

  // Outputs are registered from the next state so loading drops with the last write.
  always_comb begin
    lowByte_d = lowByte_q;
    index_d   = index_q;
    timer_d   = timer_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    progLen_d = progLen_q;
    if (btnEdge) begin
      index_d   = '0;
      timer_d   = '0;
      progLen_d = '0;
    end else if (loadState) begin
      timer_d = accepted ? 32'd0 : timer_q + 32'd1;
      if (accepted && (state_q == CNT_LO || state_q == INS_LO)) lowByte_d = rx_data;
      if (accepted && state_q == CNT_HI && countExt <= DEPTH) progLen_d = countExt[ADDR_W:0];
      if (accepted && state_q == INS_HI) begin
        we_d    = 1'b1;
        addr_d  = index_q[ADDR_W-1:0];
        wdata_d = countExt[15:0];
        index_d = indexInc;
      end
    end
    hold_d    = (state_d != RUN);
    loading_d = (state_d == CNT_LO) || (state_d == CNT_HI) ||
                (state_d == INS_LO) || (state_d == INS_HI);
    err_d     = (state_d == ERR);
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = hold_q;
  assign loading    = loading_q;
  assign prog_len   = progLen_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: expected writes go into a scoreboard queue when the
// bytes are sent, and a monitor pops and compares on every imem_we pulse.
module tb_uart_program_loader;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 100;

  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              wait_transport = 1'b1;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_hold;
  logic              loading;
  logic [ADDR_W:0]   prog_len;
  logic              load_err;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
    logic        last;
  } wr_t;

  wr_t         expQ[$];
  logic [15:0] wordsQ[$];
  int          checks = 0;
  int          errors = 0;
  bit          gapsOn = 1'b1;

  uart_program_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET), .rx_data(rx_data), .rx_valid(rx_valid),
    .wait_transport(wait_transport), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .loading(loading),
    .prog_len(prog_len), .load_err(load_err)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge so consecutive calls are back-to-back.
  task automatic applyStimulus(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
    if (gapsOn) repeat ($urandom_range(0, 3)) @(negedge CLK);
  endtask

  task automatic pressButton(input bit withByte, input logic [7:0] b, input bit checkRise);
    wait_transport = 1'b0;
    @(negedge CLK);
    if (checkRise) checkOutput("loading_early", loading, 0);
    if (withByte) begin
      rx_data  = b;
      rx_valid = 1'b1;
    end
    @(negedge CLK);
    rx_valid       = 1'b0;
    wait_transport = 1'b1;
    if (checkRise) begin
      checkOutput("loading_rise", loading, 1);
      checkOutput("hold_rise", cpu_hold, 1);
    end
  endtask

  task automatic doReset();
    RESET = 1'b0;
    @(negedge CLK);
    checkOutput("rst_we", imem_we, 0);
    checkOutput("rst_addr", imem_addr, 0);
    checkOutput("rst_wdata", imem_wdata, 0);
    checkOutput("rst_hold", cpu_hold, 0);
    checkOutput("rst_loading", loading, 0);
    checkOutput("rst_prog_len", prog_len, 0);
    checkOutput("rst_err", load_err, 0);
    RESET = 1'b1;
  endtask

  // Reference behaviour: count 0 ends with nothing written, a count above the
  // memory depth is an error, otherwise each word lands at its position in the stream.
  task automatic runLoad(input int cnt, input bit coincide, input bit checkRise);
    logic [15:0] w;
    bit          inRange;
    inRange = (cnt >= 1) && (cnt <= (1 << ADDR_W));
    pressButton(coincide, 8'h05, checkRise);
    applyStimulus(cnt[7:0]);
    applyStimulus(cnt[15:8]);
    if (inRange) begin
      for (int i = 0; i < cnt; i++) begin
        if (wordsQ.size() != 0) w = wordsQ.pop_front();
        else                    w = 16'($urandom);
        expQ.push_back(wr_t'{addr: i[7:0], data: w, last: (i == cnt - 1)});
        applyStimulus(w[7:0]);
        applyStimulus(w[15:8]);
      end
    end
    repeat (2) @(negedge CLK);
    checkOutput("drain", expQ.size(), 0);
    checkOutput("end_loading", loading, 0);
    checkOutput("end_hold", cpu_hold, 1);
    checkOutput("end_prog_len", prog_len, inRange ? cnt : 0);
    checkOutput("end_err", load_err, (cnt > (1 << ADDR_W)) ? 1 : 0);
    expQ.delete();
  endtask

  always @(negedge CLK) begin
    wr_t e;
    if (imem_we) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                 imem_addr, imem_wdata);
      end else begin
        e = expQ.pop_front();
        checkOutput("write_addr", imem_addr, e.addr);
        checkOutput("write_data", imem_wdata, e.data);
        checkOutput("write_loading", loading, e.last ? 0 : 1);
        checkOutput("write_hold", cpu_hold, 1);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] w;
    @(negedge CLK);
    doReset();

    $display("[TB] basic three-word load");
    gapsOn = 1'b0;
    wordsQ = '{16'h1234, 16'h5678, 16'h9ABC};
    runLoad(3, 1'b0, 1'b1);
    repeat (10) @(negedge CLK);
    checkOutput("hold_kept", cpu_hold, 1);
    doReset();
    gapsOn = 1'b1;

    $display("[TB] zero count and oversize count");
    runLoad(0, 1'b0, 1'b0);
    runLoad(257, 1'b0, 1'b0);
    runLoad(2, 1'b0, 1'b0);

    $display("[TB] timeout");
    pressButton(1'b0, 8'h00, 1'b0);
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    rx_data  = 8'h11;
    rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge CLK);
      if (k == TIMEOUT - 1) begin
        checkOutput("to_err_early", load_err, 0);
        checkOutput("to_loading_early", loading, 1);
      end
      if (k == TIMEOUT) begin
        checkOutput("to_err", load_err, 1);
        checkOutput("to_loading", loading, 0);
        checkOutput("to_hold", cpu_hold, 1);
      end
    end
    checkOutput("to_no_write", expQ.size(), 0);

    $display("[TB] restart mid-load and coinciding edge");
    pressButton(1'b0, 8'h00, 1'b0);
    applyStimulus(8'h03);
    applyStimulus(8'h00);
    w = 16'($urandom);
    expQ.push_back(wr_t'{addr: 8'h00, data: w, last: 1'b0});
    applyStimulus(w[7:0]);
    applyStimulus(w[15:8]);
    repeat (2) @(negedge CLK);
    checkOutput("restart_first", expQ.size(), 0);
    runLoad(2, 1'b0, 1'b0);
    runLoad(1, 1'b1, 1'b0);

    $display("[TB] reset mid-load");
    pressButton(1'b0, 8'h00, 1'b0);
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    applyStimulus(8'h77);
    doReset();
    applyStimulus(8'h88);
    repeat (2) @(negedge CLK);
    checkOutput("post_rst_hold", cpu_hold, 0);
    checkOutput("post_rst_we", imem_we, 0);

    $display("[TB] back-to-back bytes and full-depth load");
    gapsOn = 1'b0;
    runLoad(1, 1'b0, 1'b0);
    gapsOn = 1'b1;
    runLoad(1 << ADDR_W, 1'b0, 1'b0);

    $display("[TB] random loads");
    repeat (4) runLoad($urandom_range(1, 20), 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_program_loader.md
# uart_program_loader

Program-load controller between the UART byte receiver and the CPU instruction memory in the single-cycle CPU system. On a `wait_transport` press it halts the CPU and lights the loading LED. It then takes a little-endian 16-bit instruction count and that many little-endian 16-bit instruction words from the byte stream, writing each word into instruction memory. It releases the LED when done and holds the CPU until the next `RESET` press starts execution.

## Interface
- `ADDR_W`, 8: instruction memory address width; depth = 2^ADDR_W words.
- `TIMEOUT_CYCLES`, 1_000_000: maximum CLK cycles between accepted bytes while loading; 0 disables the timeout.
- `CLK`  in  1  system clock, 50 MHz.
- `RESET`  in  1  reset: one clock; reset is synchronous and active-low.
- `rx_data`  in  8  byte from the UART receiver.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in the same cycle.
- `wait_transport`  in  1  active-low load button, already synchronised and debounced.
- `imem_we`  out  1  one-cycle instruction memory write strobe.
- `imem_addr`  out  ADDR_W  write address.
- `imem_wdata`  out  16  write data.
- `cpu_hold`  out  1  1 = CPU PC/register writes frozen.
- `loading`  out  1  1 = load in progress; drives `led4`.
- `prog_len`  out  ADDR_W+1  latched instruction count.
- `load_err`  out  1  sticky error flag.

## Operation
- States: RUN, CNT_LO, CNT_HI, INS_LO, INS_HI, DONE, ERR.
- Synchronous reset (`RESET`=0 at an edge) gives the following values:
  - state = RUN, all outputs 0, byte index 0, timeout counter 0.
  - previous-button register = 1.
- Load start is a falling edge of `wait_transport` (previous=1, current=0).
  - From any state it moves to CNT_LO and clears the index, timeout counter, `load_err` and `prog_len`.
  - If it coincides with `rx_valid`, the edge wins and the byte is discarded.
- CNT_LO: on `rx_valid`, latch the low count byte and go to CNT_HI.
- CNT_HI: on `rx_valid`, form count = {rx_data, lo}.
  - count = 0: go to DONE with `prog_len`=0.
  - count > 2^ADDR_W: go to ERR.
  - Otherwise latch `prog_len` and go to INS_LO.
- INS_LO: on `rx_valid`, latch the low byte and go to INS_HI.
- INS_HI: on `rx_valid`, register a write: `imem_we`=1, `imem_addr`=index, `imem_wdata`={rx_data, lo}, then increment the index.
  - If index+1 == `prog_len`, go to DONE.
  - Otherwise go to INS_LO.
- The timeout counter increments each cycle in CNT_*/INS_* and clears on every accepted byte. Reaching TIMEOUT_CYCLES-1 with no byte moves the block to ERR.
- DONE: `cpu_hold`=1, `loading`=0. The block stays here; only `RESET` (back to RUN) or a new button edge exits.
- ERR: `cpu_hold`=1, `loading`=0, `load_err`=1. It exits the same way as DONE. Partially written memory is left as is.
- RUN ignores `rx_valid`. `rx_valid` is ignored in DONE/ERR.
- Index arithmetic is ADDR_W+1 bits, so a full-depth load (count = 2^ADDR_W) terminates without address wrap.
- Reset mid-load abandons the load immediately. There are no further writes, and `imem_we` is 0 in the cycle after reset.

## Timing
- All outputs are registered.
- `imem_we` is high for exactly the one cycle after the edge that accepted the MSB byte.
  - `imem_addr`/`imem_wdata` are valid in that cycle.
  - They hold their value afterwards; their content is only meaningful when `imem_we`=1.
- `cpu_hold`/`loading` rise in the cycle after the button edge is sampled, i.e. 2 cycles after `wait_transport` falls.
- `loading` falls in the same cycle the last `imem_we` pulse is high.
- Back-to-back `rx_valid` on consecutive cycles must be accepted without loss. The block has no backpressure.
- Timeout: ERR is entered exactly TIMEOUT_CYCLES cycles after the last accepted byte, or after load start if no byte has arrived.

## Test plan
- Reset, button press, then bytes 03 00 / 34 12 / 78 56 / BC 9A:
  - three `imem_we` pulses with addr 0,1,2 and data 0x1234, 0x5678, 0x9ABC;
  - `prog_len`=3;
  - `loading` 1→0 on the third pulse;
  - `cpu_hold` stays 1 until `RESET`, then returns to 0.
- Count 00 00 → DONE with no writes, `prog_len`=0, `loading`=0.
- ADDR_W=8, count 01 01 (257) → ERR with `load_err`=1 and no writes. A subsequent button press clears `load_err` and accepts a valid load.
- TIMEOUT_CYCLES=100: send count 02 00 and one byte, then silence → ERR exactly 100 cycles after that byte; `imem_we` never asserted.
- Restart and reset mid-load:
  - button press after the first instruction is written → restart at CNT_LO, next write goes to addr 0;
  - a button edge coinciding with `rx_valid` discards that byte;
  - `RESET` asserted mid-INS_HI → RUN with all outputs 0.
- Byte timing and full-depth load:
  - `rx_valid` on consecutive cycles: count 01 00 plus 2 bytes in 4 successive cycles → one write of the correct word;
  - full-depth load of 256 words → last write at addr 0xFF, then DONE.
